// File: rtl/y86_fetch_unit_if.sv
// Fetch-unit bundle: next-PC strobe, byte-wide instruction-memory bus and
// the decoded-instruction valid/ready handshake toward decode/execute.
interface y86_fetch_unit_if #(parameter int ADDR_W = 16);
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [7:0]        imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [63:0]       valC;
    logic [ADDR_W-1:0] valP;
    logic [2:0]        stat;
    logic [ADDR_W-1:0] pc_out;
    logic              busy;

    modport master (
        input  pc_valid, pc_in, imem_data, out_ready,
        output imem_addr, imem_rd, out_valid, icode, ifun, rA, rB, valC, valP,
               stat, pc_out, busy
    );

    modport slave (
        output pc_valid, pc_in, imem_data, out_ready,
        input  imem_addr, imem_rd, out_valid, icode, ifun, rA, rB, valC, valP,
               stat, pc_out, busy
    );
endinterface

// File: rtl/y86_fetch_unit.sv
// Multi-cycle Y86-64 fetch: one instruction byte per cycle from a byte-wide
// synchronous memory, assembled into icode/ifun/rA/rB/valC/valP.
module y86_fetch_unit #(
    parameter int                ADDR_W    = 16,
    parameter int                MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    y86_fetch_unit_if.master bus
);
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {IDLE, FETCH, DONE, HALTED} state_t;

    state_t            state, nstate;
    logic [ADDR_W-1:0] pc_r, valp_r;
    logic [3:0]        cnt, icode_r, ifun_r, ra_r, rb_r;
    logic [63:0]       valc_r;
    logic [2:0]        stat_r;

    logic [3:0]        cur_icode, len;
    logic [2:0]        vc_idx;
    logic [ADDR_W:0]   addr_sum;
    logic              addr_err, need_rd, last, fetch_err, start;

    function automatic logic [3:0] ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: ilen = 4'd2;
            4'h7, 4'h8:             ilen = 4'd9;
            4'h3, 4'h4, 4'h5:       ilen = 4'd10;
            default:                ilen = 4'd1;
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] ic);
        has_regs = (ic >= 4'h2 && ic <= 4'h6) || ic == 4'hA || ic == 4'hB;
    endfunction

    function automatic logic is_jc(input logic [3:0] ic);
        is_jc = (ic == 4'h7) || (ic == 4'h8);
    endfunction

    function automatic logic is_mc(input logic [3:0] ic);
        is_mc = (ic >= 4'h3) && (ic <= 4'h5);
    endfunction

    // cnt counts FETCH cycles; in cycle k>=1 imem_data carries byte k-1.
    // The length is only known once byte 0 is on the bus (cnt==1).
    always_comb begin
        cur_icode = (cnt == 4'd1) ? bus.imem_data[7:4] : icode_r;
        len       = ilen(cur_icode);
        addr_sum  = {1'b0, pc_r} + (ADDR_W+1)'(cnt);
        addr_err  = addr_sum[ADDR_W] || (32'(addr_sum) >= 32'(MEM_BYTES));
        need_rd   = (cnt == 4'd0) || (cnt < len);
        last      = (cnt != 4'd0) && (cnt == len);
        fetch_err = need_rd && addr_err;
        vc_idx    = is_jc(icode_r) ? 3'(cnt - 4'd2) : 3'(cnt - 4'd3);
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= FETCH;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.pc_valid) nstate = FETCH;
            FETCH:   if (last || fetch_err) nstate = DONE;
            DONE:    if (bus.out_ready) begin
                         if (stat_r != S_AOK)   nstate = HALTED;
                         else if (bus.pc_valid) nstate = FETCH;
                         else                   nstate = IDLE;
                     end
            default: nstate = HALTED;
        endcase
    end

    assign start = (nstate == FETCH) && (state != FETCH);

    always_ff @(posedge CLK) begin
        if (RESET || start) begin
            pc_r    <= RESET ? RESET_PC : bus.pc_in;
            cnt     <= 4'd0;
            icode_r <= 4'h0;
            ifun_r  <= 4'h0;
            ra_r    <= 4'hF;
            rb_r    <= 4'hF;
            valc_r  <= 64'd0;
            valp_r  <= '0;
            stat_r  <= S_AOK;
        end else if (state == FETCH) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd1) begin
                icode_r <= bus.imem_data[7:4];
                ifun_r  <= bus.imem_data[3:0];
            end
            if (cnt == 4'd2 && has_regs(icode_r)) begin
                ra_r <= bus.imem_data[7:4];
                rb_r <= bus.imem_data[3:0];
            end
            if ((is_jc(icode_r) && cnt >= 4'd2) || (is_mc(icode_r) && cnt >= 4'd3))
                valc_r[{vc_idx, 3'b000} +: 8] <= bus.imem_data;
            if (fetch_err) begin
                stat_r <= S_ADR;
            end else if (last) begin
                valp_r <= pc_r + ADDR_W'(len);
                stat_r <= (cur_icode > 4'hB) ? S_INS :
                          (cur_icode == 4'h0) ? S_HLT : S_AOK;
            end
        end
    end

    // A read is never issued past the last byte or onto a bad address.
    always_comb begin
        bus.out_valid = (state == DONE);
        bus.busy      = (state == FETCH);
        bus.imem_rd   = (state == FETCH) && !RESET && need_rd && !addr_err;
        bus.imem_addr = (state == FETCH) ? addr_sum[ADDR_W-1:0] : pc_r;
    end

    assign bus.icode  = icode_r;
    assign bus.ifun   = ifun_r;
    assign bus.rA     = ra_r;
    assign bus.rB     = rb_r;
    assign bus.valC   = valc_r;
    assign bus.valP   = valp_r;
    assign bus.stat   = stat_r;
    assign bus.pc_out = pc_r;
endmodule
